// File: rtl/lfi_reg_scan_sequencer.sv
// Scan controller for the laser-fault-injection register array: walks a one-hot
// enable across the registers and flags any cycle where the enabled one fails to toggle.
module lfi_reg_scan_sequencer #(
    parameter int N_REGS        = 8,
    parameter int DWELL_CYCLES  = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    localparam int IDX_W        = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              auto_mode,
    input  logic              step,
    input  logic [N_REGS-1:0] reg_q,
    output logic [N_REGS-1:0] reg_en,
    output logic [IDX_W-1:0]  active_idx,
    output logic              busy,
    output logic              dwell_done,
    output logic              scan_wrap,
    output logic              fault,
    output logic              fault_seen,
    output logic [IDX_W-1:0]  fault_idx,
    output logic [CNT_W-1:0]  fault_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL, HOLD} state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [N_REGS-1:0]   reg_en_reg, reg_en_next;
    logic [N_REGS-1:0]   q_prev_reg;
    logic                busy_reg, busy_next;
    logic                dwell_done_reg, dwell_done_next;
    logic                scan_wrap_reg, scan_wrap_next;
    logic                fault_reg, fault_next;
    logic                fault_seen_reg, fault_seen_next;
    logic [IDX_W-1:0]    fault_idx_reg, fault_idx_next;
    logic [CNT_W-1:0]    fault_count_reg, fault_count_next;

    logic                last_idx;
    logic [IDX_W-1:0]    idx_adv;
    logic [N_REGS-1:0]   en_adv;
    logic                mismatch;

    assign last_idx = (idx_reg == IDX_W'(N_REGS - 1));
    assign idx_adv  = last_idx ? '0 : idx_reg + 1'b1;
    assign en_adv   = N_REGS'(1) << idx_adv;

    // The enable mask selects the active bit, so no variable bit-select is needed.
    assign mismatch = ((|(reg_q & reg_en_reg)) == (|(q_prev_reg & reg_en_reg)))
                    || (|(reg_q & ~reg_en_reg));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            reg_en_reg      <= '0;
            q_prev_reg      <= '0;
            busy_reg        <= 1'b0;
            dwell_done_reg  <= 1'b0;
            scan_wrap_reg   <= 1'b0;
            fault_reg       <= 1'b0;
            fault_seen_reg  <= 1'b0;
            fault_idx_reg   <= '0;
            fault_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            reg_en_reg      <= reg_en_next;
            q_prev_reg      <= reg_q;
            busy_reg        <= busy_next;
            dwell_done_reg  <= dwell_done_next;
            scan_wrap_reg   <= scan_wrap_next;
            fault_reg       <= fault_next;
            fault_seen_reg  <= fault_seen_next;
            fault_idx_reg   <= fault_idx_next;
            fault_count_reg <= fault_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        idx_next         = idx_reg;
        reg_en_next      = reg_en_reg;
        dwell_done_next  = 1'b0;
        scan_wrap_next   = 1'b0;
        fault_next       = 1'b0;
        fault_seen_next  = fault_seen_reg;
        fault_idx_next   = fault_idx_reg;
        fault_count_next = fault_count_reg;

        if (stop) begin
            state_next  = IDLE;
            reg_en_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next       = SETTLE;
                        idx_next         = '0;
                        reg_en_next      = N_REGS'(1);
                        cnt_next         = SETTLE_LOAD;
                        fault_count_next = '0;
                        fault_seen_next  = 1'b0;
                        fault_idx_next   = '0;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_next = DWELL;
                        cnt_next   = DWELL_LOAD;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                DWELL: begin
                    if (mismatch) begin
                        fault_next = 1'b1;
                        if (fault_count_reg != '1)
                            fault_count_next = fault_count_reg + 1'b1;
                        if (!fault_seen_reg) begin
                            fault_seen_next = 1'b1;
                            fault_idx_next  = idx_reg;
                        end
                    end
                    if (cnt_reg == '0) begin
                        dwell_done_next = 1'b1;
                        if (auto_mode) begin
                            state_next     = SETTLE;
                            cnt_next       = SETTLE_LOAD;
                            idx_next       = idx_adv;
                            reg_en_next    = en_adv;
                            scan_wrap_next = last_idx;
                        end else begin
                            state_next = HOLD;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (step) begin
                        state_next     = SETTLE;
                        cnt_next       = SETTLE_LOAD;
                        idx_next       = idx_adv;
                        reg_en_next    = en_adv;
                        scan_wrap_next = last_idx;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    assign reg_en      = reg_en_reg;
    assign active_idx  = idx_reg;
    assign busy        = busy_reg;
    assign dwell_done  = dwell_done_reg;
    assign scan_wrap   = scan_wrap_reg;
    assign fault       = fault_reg;
    assign fault_seen  = fault_seen_reg;
    assign fault_idx   = fault_idx_reg;
    assign fault_count = fault_count_reg;

endmodule

// File: doc/lfi_reg_scan_sequencer.md
Name: lfi_reg_scan_sequencer

Overview:
- Controller for the laser-fault-injection register-location array, where each register toggles every clock while its enable is high and is held at 0 otherwise.
- Drives the array's per-register enables one-hot, dwelling on each register for a fixed number of cycles while the laser is positioned.
- Checks the array's outputs every cycle during the dwell window and counts and flags any deviation from the expected pattern (a candidate fault hit).
- Sits between the external control pins and the register array, in the same clock domain as the array.

Parameters:
- N_REGS, 8, number of registers in the array; width of the enable and observe vectors.
- DWELL_CYCLES, 1024, checked cycles per register; must be at least 1.
- SETTLE_CYCLES, 4, unchecked cycles after each enable change; must be at least 2.
- CNT_W, 16, width of the dwell counter and the fault counter.
- IDX_W, derived as clog2(N_REGS) with a minimum of 1; localparam, not overridable.

Ports:
- clk  in  1  system clock; the array's clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a scan at index 0; accepted only in IDLE.
- stop  in  1  abort to IDLE from any state.
- auto_mode  in  1  1 means advance automatically; 0 means wait for step after each dwell. Sampled at each dwell end.
- step  in  1  advance to the next register while in HOLD.
- reg_q  in  N_REGS  observed register outputs from the array.
- reg_en  out  N_REGS  one-hot enables to the array; all zero when idle.
- active_idx  out  IDX_W  index of the currently enabled register.
- busy  out  1  high in every state except IDLE.
- dwell_done  out  1  one-cycle pulse on the last DWELL cycle.
- scan_wrap  out  1  one-cycle pulse when the index wraps from N_REGS-1 to 0.
- fault  out  1  one-cycle pulse on each mismatching DWELL cycle.
- fault_seen  out  1  sticky flag; cleared by an accepted start.
- fault_idx  out  IDX_W  active_idx at the first fault since the last accepted start.
- fault_count  out  CNT_W  number of mismatching cycles since start; saturates at all ones.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; reg_en=0, active_idx=0, busy=0, all pulses 0, fault_seen=0, fault_idx=0, fault_count=0.
- All outputs are registered.
- States: IDLE, SETTLE, DWELL, HOLD.
- IDLE:
  - start high and stop low: next state SETTLE, active_idx=0, reg_en=1 (bit 0), fault_count=0, fault_seen=0, fault_idx=0, counter loaded with SETTLE_CYCLES-1.
- SETTLE:
  - Counts down; no checking.
  - At 0: go to DWELL, counter loaded with DWELL_CYCLES-1.
- DWELL, every cycle:
  - Mismatch if reg_q[active_idx] equals its value in the previous cycle (register failed to toggle).
  - Mismatch also if any other reg_q bit is 1.
  - On the first DWELL cycle, the "previous value" is reg_q sampled on the last SETTLE cycle.
  - On a mismatch: fault=1; fault_count increments with saturation; if fault_seen=0, fault_idx=active_idx and fault_seen=1.
- DWELL end (counter 0): dwell_done=1.
  - auto_mode=1: index advances, wrapping N_REGS-1 to 0 with scan_wrap=1; reg_en moves to the new one-hot bit in the same edge; go to SETTLE.
  - auto_mode=0: go to HOLD with reg_en unchanged (the register keeps toggling, unchecked).
- HOLD:
  - step high: advance the index exactly as on an auto advance and go to SETTLE.
  - The scan runs indefinitely until stop.
- stop high in any state: next edge gives IDLE with reg_en=0 and busy=0. The fault counter and flags are retained.
  - stop has priority over start, step and dwell-end advance in the same cycle.
- start outside IDLE is ignored.
- Reset mid-scan has the same effect as reset from idle; the counters clear.
- Latency: the reg_en change is visible the cycle after the triggering edge. The SETTLE_CYCLES≥2 rule absorbs the array's one-cycle enable-to-toggle delay and the old register's clear.
- N_REGS=1: the index always stays 0, and scan_wrap pulses on every advance.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then drive start=0 for 10 cycles -> reg_en=0, busy=0, fault_count=0 throughout.
- Auto scan with an ideal array model: N_REGS=4, DWELL_CYCLES=8, SETTLE_CYCLES=2, auto_mode=1, start pulse ->
  - reg_en steps 0001, 0010, 0100, 1000, 0001;
  - each index lasts 10 cycles;
  - dwell_done pulses every 10 cycles;
  - scan_wrap fires once, 40 cycles after the first enable;
  - fault_count=0.
- Injected fault: force reg_q[2] stuck for 3 DWELL cycles while index 2 is active -> fault pulses 3 times, fault_count=3, fault_seen=1, fault_idx=2.
- Stray bit: set reg_q[0]=1 for 1 cycle during index 3's dwell -> fault_count increments by 1 and fault_idx=3 (first fault).
- Manual mode: auto_mode=0 -> after index 0's dwell, state HOLD with reg_en=0001 held for 50 cycles and no faults counted; step pulse -> reg_en=0010 on the next cycle.
- Priority and saturation:
  - start, stop and step together in DWELL -> IDLE, reg_en=0.
  - CNT_W=4 with a stuck register for 20 cycles -> fault_count=15, saturated.
